// File: rtl/hv_to_axi4_video_conv_pkg.sv
// Shared types for the HV-to-AXI4-Stream video converter: component width,
// default-width FIFO entry layout and the framing FSM states.
package hv_video_pkg;

  localparam int COMP_W       = 8;
  localparam int PX_WIDTH_DEF = 10;
  localparam int TDATA_W_DEF  = 3 * PX_WIDTH_DEF;

  typedef struct packed {
    logic                   tuser;
    logic                   tlast;
    logic [TDATA_W_DEF-1:0] tdata;
  } px_entry_t;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } fsm_state_t;

endpackage

// File: rtl/hv_to_axi4_video_conv_if.sv
// AXI4-Stream video bus (tvalid/tready/tdata/tlast/tuser) with master and slave views.
interface axi4_stream_if #(
  parameter int DATA_W = 30
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/hv_to_axi4_video_conv_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head while !empty.
// Writes when full are refused unless a read frees the slot in the same cycle.
module hv_px_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit distinguishes a full wrap from empty.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hv_to_axi4_video_conv.sv
// HV video to AXI4-Stream: input pixel reaches tvalid two edges after it is sampled.
// Downstream stalls fill the FIFO; a full-FIFO push drops the rest of the frame.
module hv_to_axi4_video_conv
  import hv_video_pkg::*;
#(
  parameter int PX_WIDTH   = 10,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [COMP_W-1:0] red_i,
  input  logic [COMP_W-1:0] green_i,
  input  logic [COMP_W-1:0] blue_i,
  input  logic              px_valid_i,
  input  logic              v_sync_i,
  axi4_stream_if.master     axi4_video_o,
  output logic              overflow_o
);
  localparam int DATA_W = 3 * PX_WIDTH;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
  } entry_t;

  function automatic logic [PX_WIDTH-1:0] widen(input logic [COMP_W-1:0] c);
    logic [PX_WIDTH-1:0] w;
    w = '0;
    w[PX_WIDTH-1 -: COMP_W] = c;
    return w;
  endfunction

  logic [COMP_W-1:0] red_q, green_q, blue_q;
  logic              valid_q, vsync_q, v_sync_d;
  logic              sof_pending;
  logic              hold_vld, hold_user;
  logic [DATA_W-1:0] hold_dat;
  fsm_state_t        state, state_nxt;

  logic   rise, pop, drop, take, full, empty;
  entry_t wr_entry, rd_entry;

  assign rise = vsync_q && !v_sync_d;
  assign pop  = axi4_video_o.tready && !empty;
  assign drop = hold_vld && full && !pop;
  // Frames are only accepted once a SOF has been seen; the overflow cycle swallows its pixel.
  assign take = valid_q && !drop && ((state == ACTIVE) || sof_pending);

  assign wr_entry.tuser = hold_user;
  assign wr_entry.tlast = !valid_q;
  assign wr_entry.tdata = hold_dat;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (valid_q && sof_pending) state_nxt = ACTIVE;
      ACTIVE:   if (drop) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= WAIT_SOF;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      valid_q     <= 1'b0;
      vsync_q     <= 1'b0;
      v_sync_d    <= 1'b0;
      sof_pending <= 1'b0;
      hold_vld    <= 1'b0;
      hold_user   <= 1'b0;
      hold_dat    <= '0;
      overflow_o  <= 1'b0;
    end else begin
      red_q       <= red_i;
      green_q     <= green_i;
      blue_q      <= blue_i;
      valid_q     <= px_valid_i;
      vsync_q     <= v_sync_i;
      v_sync_d    <= vsync_q;
      sof_pending <= rise || (sof_pending && !take);
      hold_vld    <= take;
      overflow_o  <= drop;
      if (take) begin
        hold_user <= sof_pending;
        hold_dat  <= {widen(red_q), widen(blue_q), widen(green_q)};
      end
    end
  end

  hv_px_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (hold_vld && !drop),
    .wr_data (wr_entry),
    .full    (full),
    .rd_en   (axi4_video_o.tready),
    .rd_data (rd_entry),
    .empty   (empty)
  );

  assign axi4_video_o.tvalid = !empty;
  assign axi4_video_o.tdata  = empty ? '0 : rd_entry.tdata;
  assign axi4_video_o.tlast  = !empty && rd_entry.tlast;
  assign axi4_video_o.tuser  = !empty && rd_entry.tuser;

endmodule

// File: tb/tb_hv_to_axi4_video_conv.sv
// Bench for hv_to_axi4_video_conv: two instances (FIFO depth 16 and 4) share one HV source
// and are compared every cycle against a queue-based reference model.
module tb_hv_to_axi4_video_conv;
  import hv_video_pkg::*;

  localparam int PXW  = 10;
  localparam int DW   = 3 * PXW;
  localparam int NDUT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic       pv = 1'b0, vs = 1'b0;
  logic       rdy [NDUT];
  logic       ovf16, ovf4;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  bit  rand_rdy = 1'b0;
  logic [7:0] fr, fg, fb;

  axi4_stream_if #(.DATA_W(DW)) vid16 ();
  axi4_stream_if #(.DATA_W(DW)) vid4 ();

  assign vid16.tready = rdy[0];
  assign vid4.tready  = rdy[1];

  always #5 clk = ~clk;

  hv_to_axi4_video_conv #(.PX_WIDTH(PXW), .FIFO_DEPTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .px_valid_i(pv), .v_sync_i(vs), .axi4_video_o(vid16), .overflow_o(ovf16));

  hv_to_axi4_video_conv #(.PX_WIDTH(PXW), .FIFO_DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .red_i(red), .green_i(green), .blue_i(blue),
    .px_valid_i(pv), .v_sync_i(vs), .axi4_video_o(vid4), .overflow_o(ovf4));

  logic          a_vld [NDUT], a_usr [NDUT], a_lst [NDUT], a_ovf [NDUT];
  logic [DW-1:0] a_dat [NDUT];
  always_comb begin
    a_vld[0] = vid16.tvalid; a_usr[0] = vid16.tuser; a_lst[0] = vid16.tlast;
    a_dat[0] = vid16.tdata;  a_ovf[0] = ovf16;
    a_vld[1] = vid4.tvalid;  a_usr[1] = vid4.tuser;  a_lst[1] = vid4.tlast;
    a_dat[1] = vid4.tdata;   a_ovf[1] = ovf4;
  end

  function automatic int depth_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  // Each 8-bit colour scaled into the top of a 10-bit field, order red/blue/green.
  function automatic logic [DW-1:0] exp_pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [31:0] v;
    v = ((32'(r) * 4) << 20) | ((32'(b) * 4) << 10) | (32'(g) * 4);
    return v[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference model: history of sampled inputs, frame/pending flags and an output queue per instance.
  typedef struct packed { logic pv; logic vs; logic [7:0] r; logic [7:0] g; logic [7:0] b; } smp_t;
  smp_t      h1, h2;
  px_entry_t mq [NDUT][$];
  px_entry_t mheld [NDUT];
  bit        mheld_v [NDUT], in_frame [NDUT], pending [NDUT], ovf_exp [NDUT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDUT; i++) begin
        mq[i].delete();
        mheld_v[i] = 0; in_frame[i] = 0; pending[i] = 0; ovf_exp[i] = 0;
      end
      h1 = '0; h2 = '0;
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        bit popped, lost;
        popped = (mq[i].size() > 0) && rdy[i];
        lost   = mheld_v[i] && (mq[i].size() == depth_of(i)) && !popped;
        if (popped) void'(mq[i].pop_front());
        ovf_exp[i] = lost;
        if (mheld_v[i] && !lost)
          mq[i].push_back('{tuser: mheld[i].tuser, tlast: !h1.pv, tdata: mheld[i].tdata});
        mheld_v[i] = 0;
        if (lost) in_frame[i] = 0;
        else if (h1.pv && (in_frame[i] || pending[i])) begin
          mheld_v[i] = 1;
          mheld[i] = '{tuser: pending[i], tlast: 1'b0, tdata: exp_pack(h1.r, h1.g, h1.b)};
          if (pending[i]) begin pending[i] = 0; in_frame[i] = 1; end
        end
        if (h1.vs && !h2.vs) pending[i] = 1;
      end
      h2 = h1;
      h1 = '{pv: pv, vs: vs, r: red, g: green, b: blue};
    end
  end

  int          beats [NDUT], ovfs [NDUT];
  logic [31:0] umask [NDUT], lmask [NDUT];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        px_entry_t e;
        e = (mq[i].size() != 0) ? mq[i][0] : '0;
        chk($sformatf("tvalid[%0d]", i), 32'(a_vld[i]), 32'(mq[i].size() != 0));
        chk($sformatf("tdata[%0d]", i), 32'(a_dat[i]), 32'(e.tdata));
        chk($sformatf("tuser[%0d]", i), 32'(a_usr[i]), 32'(e.tuser));
        chk($sformatf("tlast[%0d]", i), 32'(a_lst[i]), 32'(e.tlast));
        chk($sformatf("overflow[%0d]", i), 32'(a_ovf[i]), 32'(ovf_exp[i]));
        if (a_ovf[i]) ovfs[i]++;
        if (a_vld[i] && rdy[i]) begin
          if (beats[i] < 32) begin
            if (a_usr[i]) umask[i][beats[i]] = 1'b1;
            if (a_lst[i]) lmask[i][beats[i]] = 1'b1;
          end
          beats[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      rdy[0] = 1'($urandom_range(0, 1));
      rdy[1] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NDUT; i++) begin
      beats[i] = 0; ovfs[i] = 0; umask[i] = '0; lmask[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = 1'b0; vs = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic idle(input int n);
    pv = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vsync();
    vs = 1'b1; tick(); tick();
    vs = 1'b0; tick();
  endtask

  task automatic line(input int len, input bit rnd);
    for (int p = 0; p < len; p++) begin
      pv = 1'b1;
      if (rnd) begin
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      end else begin
        red = fr; green = fg; blue = fb;
      end
      tick();
    end
    pv = 1'b0;
  endtask

  task automatic frame(input int nl, input int len, input int gap, input bit rnd);
    vsync();
    idle(2);
    repeat (nl) begin
      line(len, rnd);
      idle(gap);
    end
  endtask

  task automatic chk_stats(input string tag, input int i, input int nb, input logic [31:0] um, input logic [31:0] lm);
    chk({tag, "_beats"}, 32'(beats[i]), 32'(nb));
    chk({tag, "_tuser_pos"}, umask[i], um);
    chk({tag, "_tlast_pos"}, lmask[i], lm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    clear_stats();
    do_reset();
    chk_en = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_tvalid", 32'(a_vld[i]), 32'd0);
      chk("rst_tdata", 32'(a_dat[i]), 32'd0);
      chk("rst_tuser", 32'(a_usr[i]), 32'd0);
      chk("rst_tlast", 32'(a_lst[i]), 32'd0);
      chk("rst_overflow", 32'(a_ovf[i]), 32'd0);
    end

    // 3x4 frame, constant colour, latency of first pixel.
    fr = 8'hAA; fg = 8'h55; fb = 8'h0F;
    vsync(); idle(2);
    line(1, 0); chk("lat_edge_k", 32'(a_vld[0]), 32'd0);
    line(1, 0); chk("lat_edge_k1", 32'(a_vld[0]), 32'd0);
    line(1, 0); chk("lat_edge_k2", 32'(a_vld[0]), 32'd1);
    chk("first_tdata", 32'(a_dat[0]), 32'h2A80F154);
    chk("first_tuser", 32'(a_usr[0]), 32'd1);
    line(1, 0);
    idle(3); line(4, 0); idle(3); line(4, 0); idle(12);
    for (int i = 0; i < NDUT; i++) chk_stats("frame3x4", i, 12, 32'h1, 32'h888);

    // Pixels before any v_sync edge are discarded.
    do_reset();
    line(3, 1); idle(3);
    frame(2, 2, 2, 1); idle(10);
    for (int i = 0; i < NDUT; i++) chk_stats("presync", i, 4, 32'h1, 32'hA);

    // Stalled 2x4 frame: depth 16 holds it, depth 4 overflows.
    do_reset();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    fr = 8'h12; fg = 8'h34; fb = 8'h56;
    frame(2, 4, 2, 0);
    chk("stall_tdata_a", 32'(a_dat[0]), 32'(exp_pack(8'h12, 8'h34, 8'h56)));
    idle(5);
    chk("stall_tdata_b", 32'(a_dat[0]), 32'(exp_pack(8'h12, 8'h34, 8'h56)));
    chk("stall_tvalid", 32'(a_vld[0]), 32'd1);
    chk("stall_no_ovf16", 32'(ovfs[0]), 32'd0);
    chk("stall_ovf4", 32'(ovfs[1]), 32'd1);
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    idle(15);
    chk_stats("stall16", 0, 8, 32'h1, 32'h88);
    chk_stats("stall4", 1, 4, 32'h1, 32'h8);

    // 6-pixel line into depth 4, then recovery on the next frame.
    do_reset();
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    vsync(); idle(2); line(6, 1); idle(4);
    chk("ovf6_once", 32'(ovfs[1]), 32'd1);
    chk("ovf6_none16", 32'(ovfs[0]), 32'd0);
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    idle(8);
    chk_stats("ovf6_drain", 1, 4, 32'h1, 32'h0);
    frame(1, 3, 2, 1); idle(8);
    chk_stats("ovf6_next", 1, 7, 32'h11, 32'h40);
    chk_stats("ovf6_ref16", 0, 9, 32'h41, 32'h120);

    // Reset in the middle of a line.
    do_reset();
    vsync(); idle(2); line(3, 1);
    pv = 1'b1; rst = 1'b1; tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("midrst_tvalid", 32'(a_vld[i]), 32'd0);
      chk("midrst_tlast", 32'(a_lst[i]), 32'd0);
      chk("midrst_ovf", 32'(a_ovf[i]), 32'd0);
    end
    rst = 1'b0;
    clear_stats();
    line(3, 1); idle(6);
    for (int i = 0; i < NDUT; i++) chk("midrst_silent", 32'(beats[i]), 32'd0);
    frame(1, 2, 2, 1); idle(8);
    for (int i = 0; i < NDUT; i++) chk_stats("midrst_resume", i, 2, 32'h1, 32'h2);

    // Single-pixel lines.
    do_reset();
    vsync(); idle(2); line(1, 1); idle(3); line(1, 1); idle(8);
    for (int i = 0; i < NDUT; i++) chk_stats("onepx", i, 2, 32'h1, 32'h3);

    // Random frames with random backpressure.
    do_reset();
    rand_rdy = 1'b1;
    repeat (8) frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 3), 1);
    rand_rdy = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    idle(40);
    for (int i = 0; i < NDUT; i++) chk("rand_drained", 32'(a_vld[i]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_to_axi4_video_conv.md
Name: hv_to_axi4_video_conv

Overview:
- Converts parallel HV-timed video into AXI4-Stream video.
- Inputs are 8-bit RGB, pixel-valid (DE) and v_sync, as produced by a video input/capture front end.
- Generates tuser on the first pixel of each frame and tlast on the last pixel of each line.
- A FIFO absorbs downstream backpressure, because the HV source cannot stall. On overflow the block drops data until the next frame so AXI framing stays consistent.

Parameters:
- PX_WIDTH, 10, bits per colour component in tdata; must be >= 8.
- FIFO_DEPTH, 2048, FIFO entries; power of two, >= 4.

Ports:
- clk_i  input  1  pixel clock
- rst_i  input  1  reset; synchronous, active-high
- red_i  input  8  red component
- green_i  input  8  green component
- blue_i  input  8  blue component
- px_valid_i  input  1  active-video (DE) qualifier
- v_sync_i  input  1  vertical sync, active-high
- axi4_video_o  axi4_stream_if.master  tdata 3*PX_WIDTH  video stream; tvalid, tready, tdata, tlast, tuser are used
- overflow_o  output  1  one-cycle pulse when a pixel is lost because the FIFO is full

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0, overflow_o=0. FIFO is empty, FSM is in WAIT_SOF, the hold register is empty, sof_pending=0 and v_sync_d=0.
- tdata packing, per component: colour occupies the upper 8 bits of its PX_WIDTH field; the lower PX_WIDTH-8 bits are 0.
  - red at [3W-1 -: W]
  - blue at [2W-1 -: W]
  - green at [W-1 -: W]
- SOF detect:
  - A v_sync_i rising edge (v_sync_i=1 while v_sync_d=0) sets sof_pending.
  - The first px_valid_i pixel while sof_pending=1 is tagged tuser=1 and clears sof_pending.
  - A rising edge in the same cycle as a valid pixel: that pixel is not tagged; the next frame's first pixel is.
- Line end, one-pixel look-ahead hold register:
  - A valid pixel is captured into the hold register.
  - On the next cycle the held pixel is pushed with tlast = ~px_valid_i.
  - Each contiguous px_valid_i run forms one line; line length is not checked against any resolution.
- FSM:
  - WAIT_SOF: input pixels are discarded. On a px_valid_i pixel with sof_pending=1 -> ACTIVE; that pixel enters the hold register tagged tuser.
  - ACTIVE: every hold-register push writes to the FIFO. A push while the FIFO is full -> pixel dropped, overflow_o=1 for one cycle, hold register cleared, go to WAIT_SOF.
  - The truncated frame ends without a final tlast; the next frame starts with tuser.
  - A pixel arriving in the overflow cycle is also discarded.
- FIFO: first-word-fall-through, entry = {tuser, tlast, tdata}.
  - tvalid = ~empty; a pop happens on tvalid & tready.
  - A simultaneous push and pop when full is not an overflow; the pop frees the slot.
  - Pointers wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.
- Latency, FIFO empty and tready=1: a pixel presented on the inputs at edge k appears on tvalid after edge k+2. The line's last pixel cannot be tagged until px_valid_i drops.
- AXI rule: once tvalid=1, tdata/tuser/tlast are held stable until tready=1.
- Reset mid-frame: everything returns to the reset state. The output resumes only after a new v_sync_i rising edge.

Decomposition:
- Package hv_video_pkg:
  - localparam COMP_W=8
  - typedef px_entry_t: packed struct {tuser, tlast, tdata[3*PX_WIDTH-1:0]}, parameterised via width localparam
  - enum fsm_state_t {WAIT_SOF, ACTIVE}
- Sub-module hv_px_fifo, a generic synchronous FWFT FIFO:
  - parameters WIDTH, DEPTH
  - ports wr_en, wr_data, full, rd_en, rd_data, empty
  - The top level holds SOF detect, the hold register, the FSM and packing.

Test Plan:
- Frame of 3 lines x 4 pixels, tready=1, red=0xAA, green=0x55, blue=0x0F, PX_WIDTH=10 -> 12 beats, tdata={0x2A8,0x03C,0x154}. tuser only on beat 0; tlast on beats 3, 7, 11; first tvalid 2 clocks after the first pixel.
- Pixels before any v_sync_i edge, then a v_sync pulse and a 2x2 frame -> pre-sync pixels absent; output is exactly 4 beats with tuser on the first.
- tready held 0 during a 2x4 frame with FIFO_DEPTH=16, then released -> 8 beats in order with correct tlast; tdata stable while stalled; no overflow_o.
- FIFO_DEPTH=4, tready=0, 6-pixel line -> overflow_o pulses once on the 5th push; 4 beats drain without tlast; the next frame streams with tuser after its v_sync edge.
- Assert rst_i mid-line, then deassert -> tvalid=0 next cycle and the FIFO is empty; no output until the next v_sync rising edge.
- Single-pixel line (px_valid_i high for 1 cycle) -> one beat with tlast=1; with sof_pending, also tuser=1.
